// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and a constant clog2 used to size the step counter.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: WIDTH steps over sign-stripped magnitudes,
// then a final cycle that applies the result sign and publishes prod with a done pulse.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH) + 1;

  state_t          state, state_d;
  logic [W2-1:0]   mcand, mcand_d;
  logic [WIDTH-1:0] mplier, mplier_d;
  logic [W2-1:0]   acc, acc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            neg, neg_d;
  logic [W2-1:0]   prod_d;
  logic            busy_d, done_d;

  // Magnitude of an operand; the most negative value maps to 2**(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if ((SIGNED != 0) && x[WIDTH-1]) return ~x + WIDTH'(1);
    return x;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      mcand  <= mcand_d;
      mplier <= mplier_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      neg    <= neg_d;
      prod   <= prod_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    mcand_d  = mcand;
    mplier_d = mplier;
    acc_d    = acc;
    cnt_d    = cnt;
    neg_d    = neg;
    prod_d   = prod;
    busy_d   = busy;
    done_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag(a)};
          mplier_d = mag(b);
          neg_d    = (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier[0]) acc_d = acc + mcand;
        mplier_d = mplier >> 1;
        mcand_d  = mcand << 1;
        cnt_d    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_d = FIN;
      end
      FIN: begin
        prod_d  = neg ? (~acc + W2'(1)) : acc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-and-add multiplier. It is the successor to the 2-bit combinational multiplier (comb_module).
- Computes a*b over WIDTH+1 cycles.
- Uses a start/busy/done handshake.
- Supports optional two's-complement operands.
- Used wherever a wide multiply is needed without the area of a combinational array.

Parameters:
- WIDTH, 4, operand width in bits (>=2).
- SIGNED, 0, 0 = unsigned operands/result; 1 = two's-complement operands/result.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  multiplicand, captured on accepted start.
- b  input  WIDTH  multiplier, captured on accepted start.
- prod  output  2*WIDTH  result register; updated only on completion.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when prod holds a new result.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, prod=0, busy=0, done=0, internal accumulator, counter and latched operands cleared. Reset overrides start.
- Reset mid-operation aborts the operation: no done pulse, prod returns to 0.
- States:
  - IDLE: busy=0. At an edge with start=1, the block:
    - latches magnitudes of a and b (SIGNED=1: negate if MSB set; SIGNED=0: raw);
    - latches the sign flag neg = a[MSB]^b[MSB] (0 when SIGNED=0);
    - clears the accumulator and sets count=0;
    - moves to RUN with busy=1.
  - RUN: at each edge, if multiplier LSB=1 add the shifted multiplicand into the 2*WIDTH accumulator; then shift the multiplier right, shift the multiplicand left and increment count. After WIDTH steps (count==WIDTH-1 at that edge) go to FIN.
  - FIN: at the edge, prod <= neg ? -acc : acc (2*WIDTH-bit two's complement); done=1, busy=0, state=IDLE.
- Latency: start accepted at edge E0; RUN steps occur at edges E1..EWIDTH; prod and done update at edge E(WIDTH+1). done is high for exactly one cycle after that edge.
- Back-to-back operation:
  - start=1 in the cycle where done=1 (state IDLE) is accepted.
  - Throughput is one result per WIDTH+2 cycles.
- start while busy=1 is ignored; inputs are not re-sampled and the operation in flight is unaffected.
- a and b may change freely after the accepting edge.
- prod holds its last value between completions.
- Width rules:
  - Magnitudes are WIDTH bits unsigned; most negative input -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits.
  - The accumulator is 2*WIDTH bits and never overflows for either mode.
  - Signed results always fit in 2*WIDTH bits signed; e.g. WIDTH=4, (-8)*(-8) = +64 = 8'h40.
- Zero operand: full latency still applies (no early termination).
- Count register width: clog2(WIDTH)+1 bits; the WIDTH-1 compare must be correct for non-power-of-2 WIDTH (e.g. 5).

Decomposition:
- Shared package:
  - state encoding constants IDLE/RUN/FIN (2-bit localparams);
  - a clog2 constant function used for count width.
- No sub-module is needed: datapath and FSM together are about 150 lines in one module.

Test Plan:
- WIDTH=2, SIGNED=0: exhaustive a,b in 0..3, one start per op, wait for done. Each prod equals a*b (3*3 -> 4'd9, 2*3 -> 4'd6, 0*x -> 0); done arrives 3 edges after the start edge.
- WIDTH=8, SIGNED=0: 255*255 -> prod=16'hFE01 (65025); 128*2 -> 16'd256; busy is high for exactly 9 cycles.
- WIDTH=4, SIGNED=1: (-8)*(-8) -> 8'h40; (-8)*7 -> 8'hC8 (-56); (-1)*1 -> 8'hFF; 3*(-2) -> 8'hFA.
- Ignored start: WIDTH=4, start 5*6, pulse start with 9*9 two cycles later. Exactly one done, prod=30; the second request is dropped.
- Back-to-back: start 3*4, then assert start=1 with 7*7 in the done cycle. prod=12 with a done pulse, then prod=49 with a done pulse 6 cycles later; no idle gap is needed.
- Reset mid-op: start 15*15 (WIDTH=4), assert rst at the 3rd RUN cycle. No done pulse; prod=0, busy=0. The next start 2*3 yields prod=6 with normal latency.
